// File: rtl/lf_seq_pkg.sv
// Shared definitions for the multi-word LF adder sequencer: FSM state encoding
// and the chunk-index width derivation.
package lf_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-chunk build still needs a 1-bit index so the port is never zero-width.
  function automatic int idx_width(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/lf_seq_fsm.sv
// Control half of the sequencer: owns state, chunk index and both handshakes.
// The datapath in the top follows the accept/run/last strobes produced here.
module lf_seq_fsm
  import lf_seq_pkg::*;
#(
  parameter  int CHUNKS = 4,
  localparam int IDXW   = idx_width(CHUNKS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] idx,
  output logic            in_ready,
  output logic            out_valid,
  output logic            accept,
  output logic            run,
  output logic            last
);

  state_t          state;
  state_t          state_nxt;
  logic [IDXW-1:0] idx_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    run       = 1'b0;
    last      = (idx == IDXW'(CHUNKS - 1));
    case (state)
      IDLE: begin
        // Hold off the upstream client while reset is still asserted.
        in_ready = !rst;
        accept   = in_valid && !rst;
        if (accept) begin
          state_nxt = RUN;
          idx_nxt   = '0;
        end
      end
      RUN: begin
        run = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/lf_multiword_add_seq.sv
// Runs CHUNKS*WIDTH-bit additions through one shared WIDTH-bit LF adder, LSB chunk first.
// Define LF_SEQ_OVF_EN to add the out_ovf signed-overflow output.
module lf_multiword_add_seq
  import lf_seq_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int CHUNKS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH*CHUNKS-1:0] in_a,
  input  logic [WIDTH*CHUNKS-1:0] in_b,
  input  logic                    in_cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH*CHUNKS-1:0] out_sum,
  output logic                    out_cout,
  output logic [WIDTH-1:0]        add_a,
  output logic [WIDTH-1:0]        add_b,
  output logic                    add_cin,
  input  logic [WIDTH-1:0]        add_sum,
  input  logic                    add_cout
`ifdef LF_SEQ_OVF_EN
  ,
  output logic                    out_ovf
`endif
);

  localparam int IDXW  = idx_width(CHUNKS);
  localparam int TOTAL = WIDTH * CHUNKS;

  logic [IDXW-1:0]  idx;
  logic             accept;
  logic             run;
  logic             last;
  logic [TOTAL-1:0] a_reg;
  logic [TOTAL-1:0] b_reg;
  logic [TOTAL-1:0] result;
  logic             carry;
  logic             cout_reg;

  lf_seq_fsm #(
    .CHUNKS (CHUNKS)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .idx       (idx),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .accept    (accept),
    .run       (run),
    .last      (last)
  );

  // Adder inputs are driven only while chunks are in flight so the shared adder stays quiet.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (run) begin
      add_a   = a_reg[idx*WIDTH +: WIDTH];
      add_b   = b_reg[idx*WIDTH +: WIDTH];
      add_cin = carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      result   <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
    end else if (accept) begin
      a_reg <= in_a;
      b_reg <= in_b;
      carry <= in_cin;
    end else if (run) begin
      result[idx*WIDTH +: WIDTH] <= add_sum;
      carry                      <= add_cout;
      if (last) begin
        cout_reg <= add_cout;
      end
    end
  end

  assign out_sum  = result;
  assign out_cout = cout_reg;

`ifdef LF_SEQ_OVF_EN
  logic msb_carry_in;
  logic ovf_reg;

  // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  assign msb_carry_in = add_sum[WIDTH-1] ^ add_a[WIDTH-1] ^ add_b[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (run && last) begin
      ovf_reg <= add_cout ^ msb_carry_in;
    end
  end

  assign out_ovf = ovf_reg;
`endif

endmodule

// File: doc/lf_multiword_add_seq.md
Name: lf_multiword_add_seq

Overview:
Sequencer that runs wide additions through one shared WIDTH-bit Ladner-Fischer adder, one chunk per cycle.
- Accepts a CHUNKS*WIDTH-bit operand pair over a valid/ready handshake.
- Feeds chunks LSB-first to the external combinational adder and registers the carry between chunks.
- Assembles the full sum and presents it on an output valid/ready handshake.
- Sits between the wide-datapath clients and the existing LF adder instance; it owns the adder's inputs.

Parameters:
WIDTH, 16, chunk width; must match the shared LF adder width.
CHUNKS, 4, number of chunks per operand; >=1.
IDXW, $clog2(CHUNKS) floored at 1, chunk-index counter width (derived localparam; not overridable).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  request valid.
in_ready  out  1  sequencer can accept a request.
in_a  in  WIDTH*CHUNKS  operand A.
in_b  in  WIDTH*CHUNKS  operand B.
in_cin  in  1  carry-in for chunk 0.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_sum  out  WIDTH*CHUNKS  full sum.
out_cout  out  1  carry-out of the top chunk.
add_a  out  WIDTH  to adder operand A.
add_b  out  WIDTH  to adder operand B.
add_cin  out  1  to adder carry-in.
add_sum  in  WIDTH  from adder sum; combinational, same cycle.
add_cout  in  1  from adder carry-out.

Behaviour:
- One clock; reset is asynchronous and active-high: rst high immediately forces IDLE, idx=0, carry=0, operand/result registers=0, out_valid=0, out_cout=0, out_sum=0, add_* = 0. in_ready=1 once rst deasserts.
- States:
  - IDLE: in_ready=1. When in_valid && in_ready: latch in_a, in_b; carry<=in_cin; idx<=0; go RUN.
  - RUN: add_a=a_reg[idx*WIDTH +: WIDTH], add_b likewise, add_cin=carry. Each edge: result[idx*WIDTH +: WIDTH]<=add_sum; carry<=add_cout. If idx==CHUNKS-1: out_cout<=add_cout and go DONE; else idx<=idx+1.
  - DONE: out_valid=1; out_sum/out_cout held stable. When out_ready: go IDLE, clear out_valid.
- in_ready=0 in RUN and DONE. No request is dropped; in_valid may stay high while busy.
- add_a/add_b/add_cin are 0 outside RUN so the shared adder is quiet.
- Latency: accept at edge 0, RUN for CHUNKS cycles, out_valid high after edge CHUNKS. Throughput: one request per CHUNKS+2 cycles with out_ready held high.
- CHUNKS=1: a single RUN cycle, then DONE.
- Carry chains across all chunks: all-ones + 1 wraps the sum to 0 with out_cout=1.
- out_sum is registered; it is not combinationally tied to add_sum.
- Reset asserted mid-RUN or in DONE aborts the operation and clears all state; the in-flight result is lost.
- Inputs are sampled only on the accept edge; later changes on in_a/in_b are ignored.

Optional Feature:
LF_SEQ_OVF_EN:
- Defined: adds output port out_ovf (1 bit) = signed overflow of the top chunk, add_cout XOR carry-into-MSB. Carry-into-MSB = add_sum[WIDTH-1] ^ add_a[WIDTH-1] ^ add_b[WIDTH-1]. Registered with out_cout, reset 0, valid with out_valid.
- Undefined: the port and its logic are absent.

Decomposition:
- Shared package/header lf_seq_pkg: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the IDXW derivation function.
- One natural sub-module: lf_seq_fsm, owning state, idx and the handshake signals. The datapath (operand/result registers, chunk muxing) stays in the top.
- The LF adder itself is external and connects via the add_* ports.

Test Plan:
1. WIDTH=16, CHUNKS=4; a=0x0000_0000_0000_FFFF, b=0x1, cin=0 -> out_sum=0x0000_0000_0001_0000, out_cout=0, out_valid rises 4 cycles after accept.
2. a=0xFFFF_FFFF_FFFF_FFFF, b=0x0, cin=1 -> out_sum=0, out_cout=1; add_cin=1 on all four RUN cycles.
3. Result pending, out_ready low for 3 cycles -> out_valid stays 1, out_sum/out_cout stable, in_ready=0 despite in_valid=1; accept occurs the cycle after out_ready rises.
4. Assert rst while idx=2 in RUN -> same cycle: out_valid=0, add_*=0; after release in_ready=1 and a new request a=5, b=7 yields out_sum=12.
5. CHUNKS=1 build; a=0x8000, b=0x8000 -> out_sum=0x0000, out_cout=1, out_valid 1 cycle after accept.
6. LF_SEQ_OVF_EN defined; a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> out_sum=0x8000_0000_0000_0000, out_ovf=1, out_cout=0.
